// File: rtl/serial_add_sub_pkg.sv
// Shared encodings for multi-cycle arithmetic blocks: sequencer states and
// the add/subtract operation select.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

endpackage

// File: rtl/serial_add_sub_full_adder.sv
// One-bit full adder cell; chained DIGIT-wide to form the serial slice.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple slice,
// carry registered between digits, start/done handshake to the controller.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow
);

   localparam int N     = WIDTH / DIGIT;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
      $error("serial_add_sub: WIDTH must be >= 2 and divisible by DIGIT");
   end

   state_t             state;
   state_t             state_next;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic               carry;
   logic [CNT_W-1:0]   count;
   logic [DIGIT:0]     c;
   logic [DIGIT-1:0]   s;
   logic               last_digit;

   // Ripple slice over the low digit; c[0] is the carry held from the previous digit.
   assign c[0] = carry;
   for (genvar i = 0; i < DIGIT; i++) begin : g_slice
      full_adder u_fa (
         .a    (a_sh[i]),
         .b    (b_sh[i]),
         .cin  (c[i]),
         .sum  (s[i]),
         .cout (c[i+1])
      );
   end

   assign last_digit = (state == ST_RUN) && (count == CNT_W'(N - 1));

   always_comb begin
      state_next = state;
      unique case (state)
         ST_IDLE: if (start)      state_next = ST_RUN;
         ST_RUN:  if (last_digit) state_next = ST_DONE;
         ST_DONE:                 state_next = ST_IDLE;
         default:                 state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         count     <= '0;
      end else begin
         state <= state_next;
         busy  <= (state_next == ST_RUN);
         done  <= (state_next == ST_DONE);
         if (state == ST_IDLE && start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            a_sh  <= a;
            b_sh  <= (sub == OP_SUB) ? ~b : b;
            carry <= sub;
            count <= '0;
         end else if (state == ST_RUN) begin
            result <= WIDTH'({s, result} >> DIGIT);
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            carry  <= c[DIGIT];
            count  <= count + CNT_W'(1);
            if (last_digit) begin
               carry_out <= c[DIGIT];
               overflow  <= c[DIGIT-1] ^ c[DIGIT];
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and reference-checked bench for serial_add_sub at 8/1 and 16/4.
module tb_serial_add_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic        start8, sub8, busy8, done8, co8, ov8;
   logic [7:0]  a8, b8, result8;
   logic        start16, sub16, busy16, done16, co16, ov16;
   logic [15:0] a16, b16, result16;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .carry_out(co8), .overflow(ov8)
   );

   serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .result(result16), .carry_out(co16), .overflow(ov16)
   );

   // Driver: one-cycle start, then scramble operands; lat counts edges after the start edge.
   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                      output logic [7:0] r, output logic co, output logic ov,
                      output int lat, output int bc, output logic dafter);
      a8 = av; b8 = bv; sub8 = sv; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = ~av; b8 = 8'($urandom); sub8 = ~sv;
      lat = 0; bc = 0;
      while (!done8 && lat < 40) begin
         if (busy8) bc++;
         @(posedge clk); #1; lat++;
      end
      if (!done8) lat = -1;
      r = result8; co = co8; ov = ov8;
      @(posedge clk); #1;
      dafter = done8;
   endtask

   task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                       output logic [15:0] r, output logic co, output logic ov,
                       output int lat, output int bc, output logic dafter);
      a16 = av; b16 = bv; sub16 = sv; start16 = 1'b1;
      @(posedge clk); #1;
      start16 = 1'b0; a16 = ~av; b16 = 16'($urandom); sub16 = ~sv;
      lat = 0; bc = 0;
      while (!done16 && lat < 40) begin
         if (busy16) bc++;
         @(posedge clk); #1; lat++;
      end
      if (!done16) lat = -1;
      r = result16; co = co16; ov = ov16;
      @(posedge clk); #1;
      dafter = done16;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start8 = 0; sub8 = 0; a8 = 8'h5A; b8 = 8'hA5;
      start16 = 1; sub16 = 0; a16 = 16'h1234; b16 = 16'h4321;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({busy8, done8, co8, ov8, result8} !== 12'h000) begin
         n_err++; $display("FAIL reset8: got %h expected 000", {busy8, done8, co8, ov8, result8});
      end
      n_vec++;
      if ({busy16, done16, co16, ov16, result16} !== 20'h00000) begin
         n_err++; $display("FAIL reset16: got %h expected 00000", {busy16, done16, co16, ov16, result16});
      end
      start16 = 0;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      logic [7:0] r; logic co, ov, da; int lat, bc;
      op8(8'h35, 8'h4A, 1'b0, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== 10'h07F) begin
         n_err++; $display("FAIL add_35_4a: got %h expected 07f", {co, ov, r});
      end
      n_vec++;
      if (lat != 8) begin n_err++; $display("FAIL add_latency: got %0d expected 8", lat); end
      n_vec++;
      if (bc != 8) begin n_err++; $display("FAIL add_busy: got %0d expected 8", bc); end
      n_vec++;
      if (da !== 1'b0) begin n_err++; $display("FAIL add_done_pulse: got %b expected 0", da); end
      op8(8'h7F, 8'h01, 1'b0, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b01, 8'h80}) begin
         n_err++; $display("FAIL add_7f_01: got %h expected 180", {co, ov, r});
      end
      op8(8'hFF, 8'h01, 1'b0, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b10, 8'h00}) begin
         n_err++; $display("FAIL add_ff_01: got %h expected 200", {co, ov, r});
      end
   endtask

   task automatic test_sub();
      logic [7:0] r; logic co, ov, da; int lat, bc;
      op8(8'h10, 8'h20, 1'b1, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b00, 8'hF0}) begin
         n_err++; $display("FAIL sub_10_20: got %h expected 0f0", {co, ov, r});
      end
      op8(8'h80, 8'h01, 1'b1, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b11, 8'h7F}) begin
         n_err++; $display("FAIL sub_80_01: got %h expected 37f", {co, ov, r});
      end
   endtask

   task automatic test_hold_start();
      int dcnt = 0; int dlat = -1; int j = 0;
      logic [7:0] r1 = '0; logic co1 = 0, ov1 = 0, b9 = 1, b10 = 0;
      a8 = 8'h35; b8 = 8'h4A; sub8 = 0; start8 = 1;
      @(posedge clk); #1;
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1;
      for (int i = 0; i <= 10; i++) begin
         if (done8) begin dcnt++; dlat = i; r1 = result8; co1 = co8; ov1 = ov8; end
         if (i == 9) b9 = busy8;
         if (i == 10) b10 = busy8;
         if (i < 10) begin @(posedge clk); #1; end
      end
      start8 = 0;
      n_vec++;
      if ({co1, ov1, r1} !== 10'h07F) begin
         n_err++; $display("FAIL hold_result: got %h expected 07f", {co1, ov1, r1});
      end
      n_vec++;
      if (dcnt != 1 || dlat != 8) begin
         n_err++; $display("FAIL hold_done_count: got %0d at %0d expected 1 at 8", dcnt, dlat);
      end
      n_vec++;
      if ({b9, b10} !== 2'b01) begin
         n_err++; $display("FAIL hold_restart_from_idle: got %b expected 01", {b9, b10});
      end
      while (!done8 && j < 20) begin @(posedge clk); #1; j++; end
      n_vec++;
      if ({co8, ov8, result8} !== {2'b10, 8'h00} || !done8) begin
         n_err++; $display("FAIL hold_second_op: got %h done %b expected 200 done 1", {co8, ov8, result8}, done8);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int dcnt = 0; logic [7:0] r; logic co, ov, da; int lat, bc;
      a8 = 8'h35; b8 = 8'h4A; sub8 = 0; start8 = 1;
      @(posedge clk); #1;
      start8 = 0;
      repeat (3) begin @(posedge clk); #1; end
      n_vec++;
      if (busy8 !== 1'b1) begin n_err++; $display("FAIL abort_pre_busy: got %b expected 1", busy8); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_vec++;
      if ({busy8, done8, co8, ov8, result8} !== 12'h000) begin
         n_err++; $display("FAIL abort_cleared: got %h expected 000", {busy8, done8, co8, ov8, result8});
      end
      for (int i = 0; i < 15; i++) begin
         if (done8 || busy8) dcnt++;
         @(posedge clk); #1;
      end
      n_vec++;
      if (dcnt != 0) begin n_err++; $display("FAIL abort_no_done: got %0d expected 0", dcnt); end
      op8(8'h10, 8'h20, 1'b1, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b00, 8'hF0} || lat != 8) begin
         n_err++; $display("FAIL abort_recover: got %h lat %0d expected 0f0 lat 8", {co, ov, r}, lat);
      end
   endtask

   task automatic test_digit4();
      logic [15:0] r; logic co, ov, da; int lat, bc;
      op16(16'hFFFF, 16'h0001, 1'b0, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b10, 16'h0000}) begin
         n_err++; $display("FAIL d4_ffff_0001: got %h expected 20000", {co, ov, r});
      end
      n_vec++;
      if (lat != 4 || bc != 4 || da !== 1'b0) begin
         n_err++; $display("FAIL d4_timing: got lat %0d busy %0d da %b expected 4 4 0", lat, bc, da);
      end
      op16(16'h8000, 16'h0001, 1'b1, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b11, 16'h7FFF}) begin
         n_err++; $display("FAIL d4_8000_0001_sub: got %h expected 37fff", {co, ov, r});
      end
      op16(16'h1234, 16'h4321, 1'b0, r, co, ov, lat, bc, da);
      n_vec++;
      if ({co, ov, r} !== {2'b00, 16'h5555}) begin
         n_err++; $display("FAIL d4_1234_4321: got %h expected 05555", {co, ov, r});
      end
   endtask

   task automatic test_random();
      logic [7:0] r, av, bv, er; logic [15:0] r16, av16, bv16, er16;
      logic co, ov, da, sv, eco, eov; int lat, bc;
      for (int i = 0; i < 1000; i++) begin
         av = 8'($urandom); bv = 8'($urandom); sv = 1'($urandom_range(0, 1));
         op8(av, bv, sv, r, co, ov, lat, bc, da);
         {eco, er} = sv ? ({1'b0, av} + {1'b0, ~bv} + 9'd1) : ({1'b0, av} + {1'b0, bv});
         eov = sv ? ((av[7] != bv[7]) && (er[7] != av[7])) : ((av[7] == bv[7]) && (er[7] != av[7]));
         n_vec++;
         if ({co, ov, r} !== {eco, eov, er} || lat != 8) begin
            n_err++;
            $display("FAIL rand8 %h %s %h: got %h lat %0d expected %h lat 8",
                     av, sv ? "-" : "+", bv, {co, ov, r}, lat, {eco, eov, er});
         end
      end
      for (int i = 0; i < 200; i++) begin
         av16 = 16'($urandom); bv16 = 16'($urandom); sv = 1'($urandom_range(0, 1));
         op16(av16, bv16, sv, r16, co, ov, lat, bc, da);
         {eco, er16} = sv ? ({1'b0, av16} + {1'b0, ~bv16} + 17'd1) : ({1'b0, av16} + {1'b0, bv16});
         eov = sv ? ((av16[15] != bv16[15]) && (er16[15] != av16[15]))
                  : ((av16[15] == bv16[15]) && (er16[15] != av16[15]));
         n_vec++;
         if ({co, ov, r16} !== {eco, eov, er16} || lat != 4) begin
            n_err++;
            $display("FAIL rand16 %h %s %h: got %h lat %0d expected %h lat 4",
                     av16, sv ? "-" : "+", bv16, {co, ov, r16}, lat, {eco, eov, er16});
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_hold_start();
      test_abort();
      test_digit4();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
